// File: rtl/serial_tx_piso.sv
// serial_tx_piso: parallel-in/serial-out transmitter with a one-word holding
// buffer. Words enter over a valid/ready handshake and leave one bit per clock
// on sout, framed by sout_valid and sout_last. A word can be held while the
// current one shifts, so consecutive words are sent with no idle cycle.
module serial_tx_piso #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic             hold_full, hold_full_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             accept;
  logic             at_last;

  // Advance the shift register by one bit toward the transmitting end.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
    else           return {1'b0, v[WIDTH-1:1]};
  endfunction

  // Pick the bit currently on the line from the shift register.
  function automatic logic line_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return v[WIDTH-1];
    else           return v[0];
  endfunction

  // The holding buffer is the only thing that can refuse a word.
  assign accept  = din_valid && !hold_full;
  assign at_last = (state == SHIFT) && (cnt == LAST_IDX);

  // Outputs depend on registered state only; nothing from din reaches them.
  assign din_ready  = !hold_full;
  assign busy       = (state == SHIFT) || hold_full;
  assign sout_valid = (state == SHIFT);
  assign sout_last  = at_last;
  assign sout       = (state == SHIFT) && line_bit(shreg);

  // State, shift register, counter and holding buffer; reset discards everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // Next-state logic: load, shift, reload from hold or direct input, or stop.
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    cnt_nxt       = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          shreg_nxt = din;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!at_last) begin
          shreg_nxt = shift_once(shreg);
          cnt_nxt   = cnt + CW'(1);
          if (accept) begin
            hold_nxt      = din;
            hold_full_nxt = 1'b1;
          end
        end else if (hold_full) begin
          // Held word follows immediately; din_ready is low so nothing new enters.
          shreg_nxt     = hold;
          hold_full_nxt = 1'b0;
          cnt_nxt       = '0;
        end else if (accept) begin
          // Hold is empty, so a word arriving on the final bit bypasses it.
          shreg_nxt = din;
          cnt_nxt   = '0;
        end else begin
          shreg_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_tx_piso.sv
// Directed testbench for serial_tx_piso: one MSB-first and one LSB-first
// instance, each checked against hand-computed bit sequences.
module tb_serial_tx_piso;

  logic       clk;
  logic       rst;
  logic [7:0] din_m, din_l;
  logic       dv_m, dv_l;
  logic       rdy_m, rdy_l;
  logic       so_m, so_l;
  logic       sv_m, sv_l;
  logic       sl_m, sl_l;
  logic       busy_m, busy_l;

  int checks = 0;
  int errors = 0;

  serial_tx_piso #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din_m), .din_valid(dv_m), .din_ready(rdy_m),
    .sout(so_m), .sout_valid(sv_m), .sout_last(sl_m), .busy(busy_m)
  );

  serial_tx_piso #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(dv_l), .din_ready(rdy_l),
    .sout(so_l), .sout_valid(sv_l), .sout_last(sl_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic test_reset;
    // during power-on reset
    checks++; if (sv_m !== 1'b0) begin errors++; $display("FAIL por_sout_valid got=%b exp=0", sv_m); end
    checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL por_din_ready got=%b exp=1", rdy_m); end
    @(negedge clk); rst = 1'b1;
    // start a frame so outputs are non-reset values
    @(posedge clk); #1; din_m = 8'hC3; dv_m = 1'b1;
    @(posedge clk); #1; dv_m = 1'b0; din_m = 8'h5A; dv_m = 1'b1;
    @(posedge clk); #1; dv_m = 1'b0;
    checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got=%b exp=1", busy_m); end
    checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL pre_reset_ready got=%b exp=0", rdy_m); end
    #2; rst = 1'b0;
    #1;
    checks++; if (so_m !== 1'b0) begin errors++; $display("FAIL async_rst_sout got=%b exp=0", so_m); end
    checks++; if (sv_m !== 1'b0) begin errors++; $display("FAIL async_rst_sout_valid got=%b exp=0", sv_m); end
    checks++; if (sl_m !== 1'b0) begin errors++; $display("FAIL async_rst_sout_last got=%b exp=0", sl_m); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL async_rst_busy got=%b exp=0", busy_m); end
    checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL async_rst_din_ready got=%b exp=1", rdy_m); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++; if (sv_m !== 1'b0) begin errors++; $display("FAIL post_rst_idle got=%b exp=0", sv_m); end
  endtask

  task automatic test_single;
    logic [7:0] w;
    w = 8'hA5;
    @(posedge clk); #1; din_m = w; dv_m = 1'b1;
    @(posedge clk); #1; dv_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (sv_m !== 1'b1) begin errors++; $display("FAIL single_valid bit=%0d got=%b exp=1", i, sv_m); end
      checks++; if (so_m !== w[7-i]) begin errors++; $display("FAIL single_bit bit=%0d got=%b exp=%b", i, so_m, w[7-i]); end
      checks++; if (sl_m !== (i == 7)) begin errors++; $display("FAIL single_last bit=%0d got=%b exp=%b", i, sl_m, (i == 7)); end
    end
    @(negedge clk);
    checks++; if (sv_m !== 1'b0) begin errors++; $display("FAIL single_end_valid got=%b exp=0", sv_m); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL single_end_busy got=%b exp=0", busy_m); end
    checks++; if (sl_m !== 1'b0) begin errors++; $display("FAIL single_end_last got=%b exp=0", sl_m); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s;
    logic        exp_rdy;
    s = {8'hA5, 8'h3C};
    @(posedge clk); #1; din_m = 8'hA5; dv_m = 1'b1;
    @(posedge clk); #1; din_m = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_rdy = !(i >= 1 && i <= 7);
      checks++; if (sv_m !== 1'b1) begin errors++; $display("FAIL b2b_valid bit=%0d got=%b exp=1", i, sv_m); end
      checks++; if (so_m !== s[15-i]) begin errors++; $display("FAIL b2b_bit bit=%0d got=%b exp=%b", i, so_m, s[15-i]); end
      checks++; if (sl_m !== (i == 7 || i == 15)) begin errors++; $display("FAIL b2b_last bit=%0d got=%b exp=%b", i, sl_m, (i == 7 || i == 15)); end
      checks++; if (rdy_m !== exp_rdy) begin errors++; $display("FAIL b2b_ready bit=%0d got=%b exp=%b", i, rdy_m, exp_rdy); end
      if (i == 0) begin
        @(posedge clk); #1; dv_m = 1'b0; din_m = 8'h00;
      end
    end
    @(negedge clk);
    checks++; if (sv_m !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got=%b exp=0", sv_m); end
  endtask

  task automatic test_backpressure;
    logic [23:0] s;
    logic [7:0]  words [3];
    logic        exp_rdy;
    int          next_w;
    int          ff_accept_at;
    s = {8'hA5, 8'h3C, 8'hFF};
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    ff_accept_at = -1;
    @(posedge clk); #1; din_m = words[0]; dv_m = 1'b1;
    @(posedge clk); #1; din_m = words[1];
    next_w = 2;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      exp_rdy = (i == 0) || (i == 8) || (i >= 16);
      checks++; if (sv_m !== 1'b1) begin errors++; $display("FAIL bp_valid bit=%0d got=%b exp=1", i, sv_m); end
      checks++; if (so_m !== s[23-i]) begin errors++; $display("FAIL bp_bit bit=%0d got=%b exp=%b", i, so_m, s[23-i]); end
      checks++; if (sl_m !== (i == 7 || i == 15 || i == 23)) begin errors++; $display("FAIL bp_last bit=%0d got=%b exp=%b", i, sl_m, (i == 7 || i == 15 || i == 23)); end
      checks++; if (rdy_m !== exp_rdy) begin errors++; $display("FAIL bp_ready bit=%0d got=%b exp=%b", i, rdy_m, exp_rdy); end
      if (dv_m && rdy_m) begin
        if (next_w == 3) ff_accept_at = i;
        @(posedge clk); #1;
        if (next_w < 3) begin
          din_m = words[next_w];
          next_w++;
        end else begin
          dv_m = 1'b0;
        end
      end
    end
    checks++; if (ff_accept_at !== 8) begin errors++; $display("FAIL bp_ff_accept_cycle got=%0d exp=8", ff_accept_at); end
    @(negedge clk);
    checks++; if (sv_m !== 1'b0) begin errors++; $display("FAIL bp_end_valid got=%b exp=0", sv_m); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL bp_end_busy got=%b exp=0", busy_m); end
  endtask

  task automatic test_lsb_first;
    logic [7:0] exp_bits;
    exp_bits = 8'b0000_0001;
    @(posedge clk); #1; din_l = 8'h01; dv_l = 1'b1;
    @(posedge clk); #1; dv_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (sv_l !== 1'b1) begin errors++; $display("FAIL lsb_valid bit=%0d got=%b exp=1", i, sv_l); end
      checks++; if (so_l !== exp_bits[i]) begin errors++; $display("FAIL lsb_bit bit=%0d got=%b exp=%b", i, so_l, exp_bits[i]); end
      checks++; if (sl_l !== (i == 7)) begin errors++; $display("FAIL lsb_last bit=%0d got=%b exp=%b", i, sl_l, (i == 7)); end
    end
    @(negedge clk);
    checks++; if (sv_l !== 1'b0) begin errors++; $display("FAIL lsb_end_valid got=%b exp=0", sv_l); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] w;
    @(posedge clk); #1; din_m = 8'hF0; dv_m = 1'b1;
    @(posedge clk); #1; din_m = 8'h3C;
    @(posedge clk); #1; dv_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (so_m !== 1'b1 || sv_m !== 1'b1) begin errors++; $display("FAIL mid_pre_bit bit=%0d got=%b/%b exp=1/1", i, so_m, sv_m); end
    end
    checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL mid_pre_busy got=%b exp=1", busy_m); end
    #2; rst = 1'b0;
    #1;
    checks++; if (so_m !== 1'b0) begin errors++; $display("FAIL mid_rst_sout got=%b exp=0", so_m); end
    checks++; if (sv_m !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", sv_m); end
    checks++; if (sl_m !== 1'b0) begin errors++; $display("FAIL mid_rst_last got=%b exp=0", sl_m); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy_m); end
    checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", rdy_m); end
    @(posedge clk); #3; rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++; if (sv_m !== 1'b0 || busy_m !== 1'b0) begin errors++; $display("FAIL mid_remnant cyc=%0d valid=%b busy=%b exp=0/0", i, sv_m, busy_m); end
    end
    w = 8'h81;
    @(posedge clk); #1; din_m = w; dv_m = 1'b1;
    @(posedge clk); #1; dv_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (sv_m !== 1'b1 || so_m !== w[7-i] || sl_m !== (i == 7)) begin
        errors++; $display("FAIL mid_after bit=%0d got=%b/%b/%b exp=1/%b/%b", i, sv_m, so_m, sl_m, w[7-i], (i == 7));
      end
    end
    @(negedge clk);
    checks++; if (sv_m !== 1'b0) begin errors++; $display("FAIL mid_after_end got=%b exp=0", sv_m); end
  endtask

  initial begin
    rst = 1'b0;
    din_m = '0; dv_m = 1'b0;
    din_l = '0; dv_l = 1'b0;
    #2;
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_lsb_first;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
